unidade_controle_param: RTL and testbench

Parametrised multi-cycle control FSM for the grupo 4 simple processor. It is the next generation of the existing control unit. It owns its own step sequencing, so no external Tstep counter is needed, and it drives the instruction fetch from the PC register. It adds add/ld/st, a configurable memory latency and a Run/Done/Busy handshake, and it drives the register-file, A/G, ULA, ADDR/DOUT and memory-write enables of the datapath.

---
 rtl/unidade_controle_param_if.sv | 38 +++
 rtl/unidade_controle_param.sv | 203 ++++++++++++++++++++
 tb/tb_unidade_controle_param.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_param_if.sv
// Control-unit <-> datapath signal bundle for the grupo 4 processor.
// master = control unit (drives strobes), slave = datapath / environment.
interface unidade_controle_param_if #(
  parameter int NREG = 8
);
  localparam int RA = $clog2(NREG);
  localparam int IW = 3 + 2 * RA;

  logic            Run;
  logic [IW-1:0]   Instrucao;
  logic            GZero;
  logic            IRin;
  logic            IncrPc;
  logic            ADDRin;
  logic            DOUTin;
  logic            W_D;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic [1:0]      Ulaop;
  logic            DINout;
  logic            Done;
  logic            Busy;

  modport master (
    input  Run, Instrucao, GZero,
    output IRin, IncrPc, ADDRin, DOUTin, W_D, Rin, Rout,
           Ain, Gin, Gout, Ulaop, DINout, Done, Busy
  );

  modport slave (
    output Run, Instrucao, GZero,
    input  IRin, IncrPc, ADDRin, DOUTin, W_D, Rin, Rout,
           Ain, Gin, Gout, Ulaop, DINout, Done, Busy
  );
endinterface

// File: rtl/unidade_controle_param.sv
// Multi-cycle control FSM for the grupo 4 processor: self-sequenced fetch
// from the PC register, mv/mvi/add/sub/ld/st/mvnz execution, configurable
// memory latency and a Run/Done/Busy handshake.
module unidade_controle_param #(
  parameter int NREG    = 8,
  parameter int MEM_LAT = 1
) (
  input logic                       Clock,
  input logic                       Resetn,
  unidade_controle_param_if.master  bus
);
  localparam int RA = $clog2(NREG);
  localparam int IW = 3 + 2 * RA;
  // Wait counter holds MEM_LAT; keep at least one bit so MEM_LAT=0 still elaborates.
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  localparam logic [CW-1:0]   LAT_LOAD = CW'(MEM_LAT);
  localparam logic [CW-1:0]   LAT_LAST = CW'(1);
  localparam logic [RA-1:0]   PC_IDX   = RA'(NREG - 1);
  localparam logic [NREG-1:0] PC_ONEHOT = {1'b1, {(NREG-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_FW, S_F1, S_T1, S_T2, S_TW, S_T3
  } state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_NOP  = 3'b111
  } opcode_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  opcode_t         op;
  logic [RA-1:0]   rx;
  logic [RA-1:0]   ry;
  logic [NREG-1:0] onehot_rx;
  logic [NREG-1:0] onehot_ry;
  logic            last_step;

  assign op        = opcode_t'(bus.Instrucao[IW-1 -: 3]);
  assign rx        = bus.Instrucao[2*RA-1:RA];
  assign ry        = bus.Instrucao[RA-1:0];
  assign onehot_rx = NREG'(1) << rx;
  assign onehot_ry = NREG'(1) << ry;

  // Identify the step that completes the current instruction (the Done state).
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    last_step = 1'b0;
    if (state == S_T3) begin
      last_step = 1'b1;
    end else if (state == S_T1) begin
      last_step = (op == OP_MV) || (op == OP_MVNZ) || (op == OP_NOP);
    end
  end

  // Step sequencing and memory wait counter.
  always_ff @(posedge Clock) begin
    // NOTE: synchronous reset; Resetn only takes effect at a rising Clock edge.
    if (!Resetn) begin
      // NOTE: non-blocking assignments for all registered state in this block.
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else if (last_step) begin
      state <= bus.Run ? S_F0 : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.Run) state <= S_F0;
        S_F0: begin
          if (MEM_LAT == 0) begin
            state <= S_F1;
          end else begin
            state    <= S_FW;
            wait_cnt <= LAT_LOAD;
          end
        end
        S_FW: begin
          if (wait_cnt == LAT_LAST) state <= S_F1;
          else                      wait_cnt <= wait_cnt - LAT_LAST;
        end
        S_F1: state <= S_T1;
        S_T1: begin
          case (op)
            OP_MVI, OP_LD: begin
              if (MEM_LAT == 0) begin
                state <= S_T3;
              end else begin
                state    <= S_TW;
                wait_cnt <= LAT_LOAD;
              end
            end
            OP_ADD, OP_SUB, OP_ST: state <= S_T2;
            default:               state <= S_IDLE;
          endcase
        end
        S_T2: state <= S_T3;
        S_TW: begin
          if (wait_cnt == LAT_LAST) state <= S_T3;
          else                      wait_cnt <= wait_cnt - LAT_LAST;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath strobes: decoded from the step and the IR contents. IR only
  // holds the new instruction from T1 on, so these cannot be precomputed a
  // cycle early.
  always_comb begin
    bus.IRin   = 1'b0;
    bus.IncrPc = 1'b0;
    bus.ADDRin = 1'b0;
    bus.DOUTin = 1'b0;
    bus.W_D    = 1'b0;
    bus.Rin    = '0;
    bus.Rout   = '0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.Gout   = 1'b0;
    bus.Ulaop  = 2'b00;
    bus.DINout = 1'b0;
    bus.Done   = last_step;
    bus.Busy   = (state != S_IDLE);
    case (state)
      S_F0: begin
        bus.Rout   = PC_ONEHOT;
        bus.ADDRin = 1'b1;
      end
      S_F1: begin
        bus.IRin   = 1'b1;
        bus.IncrPc = 1'b1;
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            bus.Rout = onehot_ry;
            bus.Rin  = onehot_rx;
          end
          OP_MVI: begin
            bus.Rout   = PC_ONEHOT;
            bus.ADDRin = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus.Rout = onehot_rx;
            bus.Ain  = 1'b1;
          end
          OP_LD, OP_ST: begin
            bus.Rout   = onehot_ry;
            bus.ADDRin = 1'b1;
          end
          OP_MVNZ: begin
            if (!bus.GZero) begin
              bus.Rout = onehot_ry;
              bus.Rin  = onehot_rx;
            end
          end
          default: ;
        endcase
      end
      S_T2: begin
        case (op)
          OP_ADD, OP_SUB: begin
            bus.Rout  = onehot_ry;
            bus.Gin   = 1'b1;
            bus.Ulaop = (op == OP_SUB) ? 2'b01 : 2'b00;
          end
          OP_ST: begin
            bus.Rout   = onehot_rx;
            bus.DOUTin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T3: begin
        case (op)
          OP_MVI: begin
            bus.DINout = 1'b1;
            bus.Rin    = onehot_rx;
            // Loading an immediate into the PC overrides the increment.
            bus.IncrPc = (rx != PC_IDX);
          end
          OP_LD: begin
            bus.DINout = 1'b1;
            bus.Rin    = onehot_rx;
          end
          OP_ADD, OP_SUB: begin
            bus.Gout = 1'b1;
            bus.Rin  = onehot_rx;
          end
          OP_ST: bus.W_D = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_unidade_controle_param.sv
// Self-checking bench for unidade_controle_param. Two instances (MEM_LAT=1
// and MEM_LAT=3) share clock and reset; a step-list model of each
// instruction supplies the expected strobes for every cycle.
module tb_unidade_controle_param;
  localparam int LOGN = 1024;

  typedef struct packed {
    logic       irin;
    logic       incrpc;
    logic       addrin;
    logic       doutin;
    logic       w_d;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [1:0] ulaop;
    logic       dinout;
    logic       done;
    logic       busy;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } exp_t;

  logic clock;
  logic resetn;
  int   cyc = 0;
  bit   checking = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  exp_t q [2][$];
  out_t log_o [2][LOGN];
  out_t act0, act1;

  unidade_controle_param_if #(.NREG(8)) bus1 ();
  unidade_controle_param_if #(.NREG(8)) bus3 ();

  unidade_controle_param #(.NREG(8), .MEM_LAT(1)) dut_l1 (
    .Clock (clock),
    .Resetn(resetn),
    .bus   (bus1)
  );

  unidade_controle_param #(.NREG(8), .MEM_LAT(3)) dut_l3 (
    .Clock (clock),
    .Resetn(resetn),
    .bus   (bus3)
  );

  assign act0 = {bus1.IRin, bus1.IncrPc, bus1.ADDRin, bus1.DOUTin, bus1.W_D, bus1.Rin,
                 bus1.Rout, bus1.Ain, bus1.Gin, bus1.Gout, bus1.Ulaop, bus1.DINout,
                 bus1.Done, bus1.Busy};
  assign act1 = {bus3.IRin, bus3.IncrPc, bus3.ADDRin, bus3.DOUTin, bus3.W_D, bus3.Rin,
                 bus3.Rout, bus3.Ain, bus3.Gin, bus3.Gout, bus3.Ulaop, bus3.DINout,
                 bus3.Done, bus3.Busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  function automatic logic [7:0] onehot(input int i);
    onehot = 8'h01 << i;
  endfunction

  // Expected strobes of one instruction, one entry per cycle from F0 to Done,
  // written straight from the instruction step table.
  task automatic push_instr(input int d, input logic [8:0] ins, input logic gz,
                            input int lat, input int start);
    out_t s[$];
    out_t b, o;
    logic [2:0] op;
    int rx, ry;
    exp_t e;
    op = ins[8:6];
    rx = int'(ins[5:3]);
    ry = int'(ins[2:0]);
    b = '0;
    b.busy = 1'b1;
    o = b; o.rout = 8'h80; o.addrin = 1'b1; s.push_back(o);
    repeat (lat) s.push_back(b);
    o = b; o.irin = 1'b1; o.incrpc = 1'b1; s.push_back(o);
    case (op)
      3'b000: begin
        o = b; o.rout = onehot(ry); o.rin = onehot(rx); o.done = 1'b1; s.push_back(o);
      end
      3'b001: begin
        o = b; o.rout = 8'h80; o.addrin = 1'b1; s.push_back(o);
        repeat (lat) s.push_back(b);
        o = b; o.dinout = 1'b1; o.rin = onehot(rx); o.incrpc = (rx != 7); o.done = 1'b1;
        s.push_back(o);
      end
      3'b010, 3'b011: begin
        o = b; o.rout = onehot(rx); o.ain = 1'b1; s.push_back(o);
        o = b; o.rout = onehot(ry); o.gin = 1'b1; o.ulaop = (op == 3'b011) ? 2'b01 : 2'b00;
        s.push_back(o);
        o = b; o.gout = 1'b1; o.rin = onehot(rx); o.done = 1'b1; s.push_back(o);
      end
      3'b100: begin
        o = b; o.rout = onehot(ry); o.addrin = 1'b1; s.push_back(o);
        repeat (lat) s.push_back(b);
        o = b; o.dinout = 1'b1; o.rin = onehot(rx); o.done = 1'b1; s.push_back(o);
      end
      3'b101: begin
        o = b; o.rout = onehot(ry); o.addrin = 1'b1; s.push_back(o);
        o = b; o.rout = onehot(rx); o.doutin = 1'b1; s.push_back(o);
        o = b; o.w_d = 1'b1; o.done = 1'b1; s.push_back(o);
      end
      3'b110: begin
        o = b; o.done = 1'b1;
        if (!gz) begin o.rin = onehot(rx); o.rout = onehot(ry); end
        s.push_back(o);
      end
      default: begin
        o = b; o.done = 1'b1; s.push_back(o);
      end
    endcase
    foreach (s[k]) begin
      e.cyc = start + k;
      e.o   = s[k];
      q[d].push_back(e);
    end
  endtask

  task automatic set_run(input int d, input logic v);
    if (d == 0) bus1.Run = v;
    else        bus3.Run = v;
  endtask

  task automatic set_ins(input int d, input logic [8:0] ins, input logic gz);
    if (d == 0) begin bus1.Instrucao = ins; bus1.GZero = gz; end
    else        begin bus3.Instrucao = ins; bus3.GZero = gz; end
  endtask

  // Called one step after a rising edge with the DUT in IDLE or its Done
  // state; returns one step after the edge that enters the Done state.
  task automatic run_instr(input int d, input logic [8:0] ins, input logic gz,
                           output int f0);
    int n;
    set_run(d, 1'b1);
    @(posedge clock); #1;
    f0 = cyc;
    set_ins(d, ins, gz);
    push_instr(d, ins, gz, (d == 0) ? 1 : 3, f0);
    n = q[d].size();
    repeat (n - 1) @(posedge clock);
    #1;
  endtask

  task automatic stop_run(input int d);
    set_run(d, 1'b0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  function automatic int done_at(input int d, input int from);
    for (int c = from; c < LOGN; c++)
      if (log_o[d][c].done === 1'b1) return c;
    return -1;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    out_t e, a;
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        e = '0;
        if (q[d].size() > 0 && q[d][0].cyc == cyc) begin
          e = q[d][0].o;
          void'(q[d].pop_front());
        end
        a = (d == 0) ? act0 : act1;
        if (cyc < LOGN) log_o[d][cyc] = a;
        check($sformatf("dut%0d_cycle%0d", d, cyc), 64'(a), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_cyc, f_mv, f_sub, f_nz1, f_nz0, f_ld, f_st, f_add, f_nop, f_same;
    int f_ab, ab_cyc, f_mvi, f_add3, f_mvi3;
    int wd_count;
    out_t t3;

    resetn = 1'b0;
    set_run(0, 1'b0); set_ins(0, 9'd0, 1'b0);
    set_run(1, 1'b0); set_ins(1, 9'd0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    resetn   = 1'b1;
    checking = 1'b1;
    r_cyc    = cyc;
    repeat (2) @(posedge clock);
    #1;

    // MEM_LAT=1 instance
    run_instr(0, 9'b000_001_010, 1'b0, f_mv);   // mv R1,R2
    stop_run(0);
    run_instr(0, 9'b011_011_100, 1'b0, f_sub);  // sub R3,R4
    stop_run(0);
    run_instr(0, 9'b110_001_010, 1'b1, f_nz1);  // mvnz R1,R2, G==0
    run_instr(0, 9'b110_001_010, 1'b0, f_nz0);  // mvnz R1,R2, G!=0
    run_instr(0, 9'b010_101_110, 1'b0, f_add);  // add R5,R6
    run_instr(0, 9'b111_000_000, 1'b0, f_nop);  // reserved -> nop
    run_instr(0, 9'b000_011_011, 1'b0, f_same); // mv R3,R3
    stop_run(0);

    // Abort add R1,R2 in its T2 step with a reset.
    set_run(0, 1'b1);
    @(posedge clock); #1;
    f_ab = cyc;
    set_ins(0, 9'b010_001_010, 1'b0);
    push_instr(0, 9'b010_001_010, 1'b0, 1, f_ab);
    repeat (4) @(posedge clock);
    #1;
    ab_cyc = cyc;
    while (q[0].size() > 0 && q[0][q[0].size()-1].cyc > ab_cyc) void'(q[0].pop_back());
    resetn = 1'b0;
    set_run(0, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    run_instr(0, 9'b001_111_000, 1'b0, f_mvi);  // mvi R7,#5
    stop_run(0);

    // MEM_LAT=3 instance, Run held across ld -> st -> add -> mvi
    run_instr(1, 9'b100_000_101, 1'b0, f_ld);   // ld R0,[R5]
    run_instr(1, 9'b101_000_110, 1'b0, f_st);   // st R0,[R6]
    run_instr(1, 9'b010_010_011, 1'b0, f_add3); // add R2,R3
    run_instr(1, 9'b001_010_000, 1'b0, f_mvi3); // mvi R2,#imm
    stop_run(1);
    repeat (3) @(posedge clock);
    #1;
    checking = 1'b0;

    // Hand-computed expectations pinning the model and the DUT.
    check("reset_idle_l1", 64'(log_o[0][r_cyc]), 64'(0));
    check("reset_idle_l3", 64'(log_o[1][r_cyc]), 64'(0));
    check("f0_pc_addr", 64'({log_o[0][f_mv].rout, log_o[0][f_mv].addrin}), 64'({8'h80, 1'b1}));
    check("f1_ir_pc", 64'({log_o[0][f_mv+2].irin, log_o[0][f_mv+2].incrpc}), 64'(2'b11));
    check("mv_t1", 64'({log_o[0][f_mv+3].rin, log_o[0][f_mv+3].rout, log_o[0][f_mv+3].done}),
          64'({8'h02, 8'h04, 1'b1}));
    check("mv_done_cycle", 64'(done_at(0, f_mv) - f_mv), 64'(3));
    check("mv_idle_busy", 64'(log_o[0][f_mv+4].busy), 64'(0));
    check("sub_t1", 64'({log_o[0][f_sub+3].rout, log_o[0][f_sub+3].ain}), 64'({8'h08, 1'b1}));
    check("sub_t2", 64'({log_o[0][f_sub+4].rout, log_o[0][f_sub+4].gin, log_o[0][f_sub+4].ulaop}),
          64'({8'h10, 1'b1, 2'b01}));
    t3 = '0; t3.gout = 1'b1; t3.rin = 8'h08; t3.done = 1'b1; t3.busy = 1'b1;
    check("sub_t3", 64'(log_o[0][f_sub+5]), 64'(t3));
    check("mvnz_gz1", 64'({log_o[0][f_nz1+3].rin, log_o[0][f_nz1+3].rout, log_o[0][f_nz1+3].done}),
          64'({8'h00, 8'h00, 1'b1}));
    check("mvnz_gz0", 64'({log_o[0][f_nz0+3].rin, log_o[0][f_nz0+3].rout}), 64'({8'h02, 8'h04}));
    check("abort_in_t2", 64'(log_o[0][ab_cyc].gin), 64'(1));
    check("abort_idle", 64'(log_o[0][ab_cyc+1]), 64'(0));
    // mvi with MEM_LAT=1: F0, FW, F1, T1, TW, T3 -> T3 is the sixth cycle
    check("abort_no_done", 64'(done_at(0, f_ab)), 64'(f_mvi + 5));
    check("mvi_pc_t3", 64'({log_o[0][f_mvi+5].rin, log_o[0][f_mvi+5].incrpc, log_o[0][f_mvi+5].dinout}),
          64'({8'h80, 1'b0, 1'b1}));
    // ld with MEM_LAT=3: F0, 3xFW, F1, T1, 3xTW, T3 -> Done on the tenth cycle
    check("ld_done_cycle", 64'(done_at(1, f_ld) - f_ld), 64'(9));
    check("ld_t3", 64'({log_o[1][f_ld+9].dinout, log_o[1][f_ld+9].rin}), 64'({1'b1, 8'h01}));
    check("st_direct_f0", 64'({log_o[1][f_ld+10].rout, log_o[1][f_ld+10].addrin}), 64'({8'h80, 1'b1}));
    wd_count = 0;
    for (int c = f_st; c < f_st + 8; c++) if (log_o[1][c].w_d === 1'b1) wd_count++;
    check("st_wd_single", 64'(wd_count), 64'(1));
    check("st_wd_t3", 64'(log_o[1][f_st+7].w_d), 64'(1));
    check("model_drained", 64'(q[0].size() + q[1].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
